// File: rtl/alu_req_receiver.sv
// alu_req_receiver: two-stage ALU endpoint between the valid/ready request and commit channels
module alu_req_receiver #(
    parameter int NUM_THREADS = 4,
    parameter int XLEN        = 32,
    parameter int NW_BITS     = 2,
    parameter int UUID_BITS   = 44,
    parameter int NR_BITS     = 5,
    localparam int NT_BITS    = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        req_valid,
    input  logic [UUID_BITS-1:0]        req_uuid,
    input  logic [NW_BITS-1:0]          req_wid,
    input  logic [NUM_THREADS-1:0]      req_tmask,
    input  logic [XLEN-1:0]             req_PC,
    input  logic [XLEN-1:0]             req_next_PC,
    input  logic [3:0]                  req_op_type,
    input  logic [2:0]                  req_op_mod,
    input  logic                        req_use_PC,
    input  logic                        req_use_imm,
    input  logic [XLEN-1:0]             req_imm,
    input  logic [NT_BITS-1:0]          req_tid,
    input  logic [NUM_THREADS*XLEN-1:0] req_rs1_data,
    input  logic [NUM_THREADS*XLEN-1:0] req_rs2_data,
    input  logic [NR_BITS-1:0]          req_rd,
    input  logic                        req_wb,
    output logic                        req_ready,
    output logic                        commit_valid,
    output logic [UUID_BITS-1:0]        commit_uuid,
    output logic [NW_BITS-1:0]          commit_wid,
    output logic [NUM_THREADS-1:0]      commit_tmask,
    output logic [XLEN-1:0]             commit_PC,
    output logic [NR_BITS-1:0]          commit_rd,
    output logic                        commit_wb,
    output logic [NUM_THREADS*XLEN-1:0] commit_data,
    input  logic                        commit_ready,
    output logic [31:0]                 perf_alu_ops
);
    localparam int SH = $clog2(XLEN);

    logic                                a_valid;
    logic [UUID_BITS-1:0]                a_uuid;
    logic [NW_BITS-1:0]                  a_wid;
    logic [NUM_THREADS-1:0]              a_tmask;
    logic [XLEN-1:0]                     a_pc;
    logic [NR_BITS-1:0]                  a_rd;
    logic                                a_wb;
    logic [3:0]                          a_op;
    logic [NUM_THREADS-1:0][XLEN-1:0]    a_opa;
    logic [NUM_THREADS-1:0][XLEN-1:0]    a_opb;
    logic [NUM_THREADS-1:0][XLEN-1:0]    res;
    logic                                stall_a;
    logic                                stall_b;
    logic                                accept;
    logic                                unused;

    assign unused    = ^{req_next_PC, req_op_mod, req_tid};
    assign stall_b   = commit_valid && !commit_ready;
    assign stall_a   = a_valid && stall_b;
    assign req_ready = !stall_a;
    assign accept    = req_valid && req_ready;

    function automatic logic [XLEN-1:0] alu(input logic [3:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        logic [SH-1:0] s;
        s = b[SH-1:0];
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a << s;
            4'd3:    return a >> s;
            4'd4:    return $signed(a) >>> s;
            4'd5:    return XLEN'($signed(a) < $signed(b));
            4'd6:    return XLEN'(a < b);
            4'd7:    return a ^ b;
            4'd8:    return a | b;
            4'd9:    return a & b;
            4'd10:   return b;
            default: return '0;
        endcase
    endfunction

    // Occupancy flags and the accepted-op counter are the only reset state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_valid      <= 1'b0;
            commit_valid <= 1'b0;
            perf_alu_ops <= '0;
        end else begin
            if (!stall_a) a_valid <= accept;
            if (!stall_b) commit_valid <= a_valid;
            if (accept) perf_alu_ops <= perf_alu_ops + 32'd1;
        end
    end

    // Stage A: capture pass-through fields and the selected operands per lane
    always_ff @(posedge clk) begin
        if (accept) begin
            a_uuid  <= req_uuid;
            a_wid   <= req_wid;
            a_tmask <= req_tmask;
            a_pc    <= req_PC;
            a_rd    <= req_rd;
            a_wb    <= req_wb;
            a_op    <= req_op_type;
            for (int i = 0; i < NUM_THREADS; i++) begin
                a_opa[i] <= req_use_PC ? req_PC : req_rs1_data[i*XLEN +: XLEN];
                a_opb[i] <= req_use_imm ? req_imm : req_rs2_data[i*XLEN +: XLEN];
            end
        end
    end

    // Per-lane result from stage-A operands; inactive lanes compute too
    always_comb begin
        res = '0;
        for (int i = 0; i < NUM_THREADS; i++) res[i] = alu(a_op, a_opa[i], a_opb[i]);
    end

    // Stage B: load only when advancing a real packet so a held commit stays stable
    always_ff @(posedge clk) begin
        if (!stall_b && a_valid) begin
            commit_uuid  <= a_uuid;
            commit_wid   <= a_wid;
            commit_tmask <= a_tmask;
            commit_PC    <= a_pc;
            commit_rd    <= a_rd;
            commit_wb    <= a_wb;
            commit_data  <= res;
        end
    end
endmodule

// File: tb/tb_alu_req_receiver.sv
// tb_alu_req_receiver: randomized scoreboard bench for alu_req_receiver
module tb_alu_req_receiver;
    logic         clk = 0, reset = 0;
    logic         req_valid = 0, req_use_PC = 0, req_use_imm = 0, req_wb = 0, req_ready;
    logic [43:0]  req_uuid = '0;
    logic [1:0]   req_wid = '0, req_tid = '0;
    logic [3:0]   req_tmask = '0, req_op_type = '0;
    logic [31:0]  req_PC = '0, req_next_PC = '0, req_imm = '0;
    logic [2:0]   req_op_mod = '0;
    logic [127:0] req_rs1_data = '0, req_rs2_data = '0;
    logic [4:0]   req_rd = '0;
    logic         commit_valid, commit_wb, commit_ready = 1;
    logic [43:0]  commit_uuid;
    logic [1:0]   commit_wid;
    logic [3:0]   commit_tmask;
    logic [31:0]  commit_PC, perf_alu_ops;
    logic [4:0]   commit_rd;
    logic [127:0] commit_data;

    alu_req_receiver dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_uuid(req_uuid), .req_wid(req_wid),
        .req_tmask(req_tmask), .req_PC(req_PC), .req_next_PC(req_next_PC), .req_op_type(req_op_type),
        .req_op_mod(req_op_mod), .req_use_PC(req_use_PC), .req_use_imm(req_use_imm), .req_imm(req_imm),
        .req_tid(req_tid), .req_rs1_data(req_rs1_data), .req_rs2_data(req_rs2_data), .req_rd(req_rd),
        .req_wb(req_wb), .req_ready(req_ready), .commit_valid(commit_valid), .commit_uuid(commit_uuid),
        .commit_wid(commit_wid), .commit_tmask(commit_tmask), .commit_PC(commit_PC), .commit_rd(commit_rd),
        .commit_wb(commit_wb), .commit_data(commit_data), .commit_ready(commit_ready),
        .perf_alu_ops(perf_alu_ops)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [43:0] uuid; logic [1:0] wid; logic [3:0] tmask; logic [31:0] pc; logic [3:0] op;
        logic use_pc; logic use_imm; logic [31:0] imm; logic [3:0][31:0] rs1; logic [3:0][31:0] rs2;
        logic [4:0] rd; logic wb;
    } req_t;
    typedef struct {
        logic [43:0] uuid; logic [1:0] wid; logic [3:0] tmask; logic [31:0] pc; logic [4:0] rd;
        logic wb; logic [3:0][31:0] data;
    } exp_t;

    exp_t         q[$];
    exp_t         mon_e;
    int           n_chk = 0, n_err = 0, acc_cnt = 0, n_commit = 0;
    logic [43:0]  next_uuid = 1;
    logic         hold = 0;
    logic [215:0] held;
    bit           rnd_on;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference arithmetic on plain 32-bit integers
    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int unsigned sh = b % 32;
        case (op)
            0: return a + b;
            1: return a - b;
            2: return a << sh;
            3: return a >> sh;
            4: return int'(a) >>> sh;
            5: return (int'(a) < int'(b)) ? 1 : 0;
            6: return (a < b) ? 1 : 0;
            7: return a ^ b;
            8: return a | b;
            9: return a & b;
            10: return b;
            default: return 0;
        endcase
    endfunction

    function automatic exp_t model(input req_t r);
        exp_t e;
        e.uuid = r.uuid; e.wid = r.wid; e.tmask = r.tmask; e.pc = r.pc; e.rd = r.rd; e.wb = r.wb;
        for (int i = 0; i < 4; i++)
            e.data[i] = ref_alu(r.op, r.use_pc ? r.pc : r.rs1[i], r.use_imm ? r.imm : r.rs2[i]);
        return e;
    endfunction

    function automatic logic [31:0] rval();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'h80000000;
            3: return 32'hFFFFFFFF;
            4: return 32'h7FFFFFFF;
            default: return $urandom;
        endcase
    endfunction

    function automatic req_t rnd_req();
        req_t r;
        r.uuid = next_uuid; r.wid = 2'($urandom); r.tmask = 4'($urandom); r.pc = rval();
        r.op = 4'($urandom); r.use_pc = ($urandom_range(0, 3) == 0); r.use_imm = ($urandom_range(0, 2) == 0);
        r.imm = rval(); r.rd = 5'($urandom); r.wb = 1'($urandom);
        for (int i = 0; i < 4; i++) begin r.rs1[i] = rval(); r.rs2[i] = rval(); end
        next_uuid++;
        return r;
    endfunction

    task automatic send(input req_t r, input bit ovr, input logic [3:0][31:0] exp_data);
        exp_t e;
        int k;
        e = model(r);
        if (ovr) e.data = exp_data;
        req_uuid = r.uuid; req_wid = r.wid; req_tmask = r.tmask; req_PC = r.pc; req_op_type = r.op;
        req_use_PC = r.use_pc; req_use_imm = r.use_imm; req_imm = r.imm; req_rs1_data = r.rs1;
        req_rs2_data = r.rs2; req_rd = r.rd; req_wb = r.wb; req_next_PC = $urandom;
        req_op_mod = 3'($urandom); req_tid = 2'($urandom); req_valid = 1;
        for (k = 0; k < 200; k++) begin
            @(negedge clk);
            if (req_ready) break;
            @(posedge clk); #1;
        end
        if (k == 200) begin
            n_chk++; n_err++;
            $display("FAIL accept_timeout: got no accept expected accept of uuid %0h", r.uuid);
            req_valid = 0;
            return;
        end
        q.push_back(e);
        @(posedge clk); #1;
        req_valid = 0;
    endtask

    task automatic drain();
        for (int k = 0; k < 200 && q.size() != 0; k++) @(negedge clk);
        chk("drain_empty", q.size(), 0);
        @(posedge clk); #1;
    endtask

    // Monitor: per-cycle counter check, hold stability, and in-order scoreboard pops
    always @(negedge clk) begin
        if (reset) begin
            hold = 0;
        end else begin
            chk("perf_count", perf_alu_ops, acc_cnt);
            if (hold) begin
                chk("hold_valid", commit_valid, 1);
                chk("hold_fields", {commit_uuid, commit_wid, commit_tmask, commit_PC, commit_rd, commit_wb, commit_data}, held);
            end
            if (commit_valid && commit_ready) begin
                if (q.size() == 0) begin
                    n_chk++; n_err++;
                    $display("FAIL unexpected_commit: got uuid %0h expected no commit", commit_uuid);
                end else begin
                    mon_e = q.pop_front();
                    n_commit++;
                    chk("uuid", commit_uuid, mon_e.uuid);
                    chk("wid", commit_wid, mon_e.wid);
                    chk("tmask", commit_tmask, mon_e.tmask);
                    chk("pc", commit_PC, mon_e.pc);
                    chk("rd", commit_rd, mon_e.rd);
                    chk("wb", commit_wb, mon_e.wb);
                    for (int i = 0; i < 4; i++)
                        if (mon_e.tmask[i]) chk($sformatf("data_lane%0d", i), commit_data[i*32 +: 32], mon_e.data[i]);
                end
            end
            hold = commit_valid && !commit_ready;
            held = {commit_uuid, commit_wid, commit_tmask, commit_PC, commit_rd, commit_wb, commit_data};
            if (req_valid && req_ready) acc_cnt++;
        end
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        req_t r;
        int ops[6] = '{4, 3, 5, 6, 1, 12};
        logic [31:0] exps[6] = '{32'hC0000000, 32'h40000000, 32'h1, 32'h0, 32'h7FFFFFFF, 32'h0};
        int c0;
        #1 reset = 1;
        #1;
        chk("rst_commit_valid", commit_valid, 0);
        chk("rst_perf", perf_alu_ops, 0);
        repeat (2) @(posedge clk);
        #1 reset = 0;
        @(negedge clk);
        chk("rst_req_ready", req_ready, 1);
        @(posedge clk); #1;

        r = rnd_req();
        r.op = 0; r.use_pc = 0; r.use_imm = 0; r.tmask = 4'hF;
        r.rs1 = {32'hFFFFFFFF, 32'd3, 32'd2, 32'd1};
        r.rs2 = {32'd1, 32'd1, 32'd1, 32'd1};
        send(r, 1, {32'd0, 32'd4, 32'd3, 32'd2});
        @(negedge clk);
        chk("lat_one_cycle", commit_valid, 0);
        @(negedge clk);
        chk("lat_two_cycles", commit_valid, 1);
        chk("lat_data", commit_data, {32'd0, 32'd4, 32'd3, 32'd2});
        chk("perf_single", perf_alu_ops, 1);
        drain();

        r = rnd_req();
        r.op = 0; r.use_pc = 1; r.use_imm = 1; r.tmask = 4'hF; r.pc = 32'h80000000; r.imm = 32'd4;
        send(r, 1, {4{32'h80000004}});
        drain();

        for (int j = 0; j < 6; j++) begin
            r = rnd_req();
            r.op = 4'(ops[j]); r.use_pc = 1; r.use_imm = 1; r.tmask = 4'hF; r.pc = 32'h80000000; r.imm = 32'h1;
            send(r, 1, {4{exps[j]}});
        end
        drain();

        reset = 1; #1; q.delete(); acc_cnt = 0; next_uuid = 1;
        @(posedge clk); #1 reset = 0;
        commit_ready = 0;
        c0 = n_commit;
        fork
            for (int j = 0; j < 5; j++) send(rnd_req(), 0, '0);
        join_none
        repeat (6) @(negedge clk);
        chk("full_req_ready", req_ready, 0);
        chk("full_commit_valid", commit_valid, 1);
        chk("full_head_uuid", commit_uuid, 1);
        chk("full_perf", perf_alu_ops, 2);
        @(posedge clk); #1 commit_ready = 1;
        wait fork;
        drain();
        chk("full_commit_count", n_commit - c0, 5);

        rnd_on = 1;
        fork
            while (rnd_on) begin
                @(posedge clk); #1;
                commit_ready = ($urandom_range(0, 3) != 0);
            end
        join_none
        for (int j = 0; j < 1000; j++) begin
            if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
            send(rnd_req(), 0, '0);
        end
        rnd_on = 0;
        repeat (2) @(posedge clk);
        #1 commit_ready = 1;
        drain();
        chk("perf_random", perf_alu_ops, acc_cnt);

        commit_ready = 0;
        send(rnd_req(), 0, '0);
        send(rnd_req(), 0, '0);
        #2 reset = 1;
        #1;
        chk("midrst_commit_valid", commit_valid, 0);
        chk("midrst_perf", perf_alu_ops, 0);
        q.delete(); acc_cnt = 0;
        @(posedge clk); #1 reset = 0;
        commit_ready = 1;
        c0 = n_commit;
        send(rnd_req(), 0, '0);
        drain();
        chk("midrst_one_commit", n_commit - c0, 1);
        chk("midrst_perf_after", perf_alu_ops, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end
endmodule
